usb_tx_encoder: RTL

USB full-speed transmit-side bit engine. It is the counterpart of the RX timer, shift and decode path.
- Pulls bytes from the TX packet logic and serialises them LSB-first.
- Applies bit stuffing and NRZI encoding, then drives D+/D−.
- Closes each packet with an EOP.
- Uses the same bit cadence as the receiver: 24 clocks per 3 bits, with a bit boundary at timer counts 7, 15 and 23.

---
 rtl/usb_tx_pkg.sv | 36 +++
 rtl/usb_tx_bit_timer.sv | 27 ++
 rtl/usb_tx_encoder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// Shared constants for the USB full-speed transmit bit engine.
// Optional feature macro: USB_TX_SYNC_GEN_EN (internal SYNC generation).
package usb_tx_pkg;

  localparam int unsigned TICK_PERIOD  = 24;
  localparam int unsigned STUFF_LEN    = 6;
  localparam int unsigned EOP_SE0_BITS = 2;
  localparam int unsigned TIMER_W      = 5;
  localparam int unsigned STATE_W      = 3;

  // Bit boundaries inside the 3-bit timer span
  localparam logic [TIMER_W-1:0] TICK_A = 5'd7;
  localparam logic [TIMER_W-1:0] TICK_B = 5'd15;
  localparam logic [TIMER_W-1:0] TICK_C = 5'd23;

  // Line levels as {dplus, dminus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // State encoding
  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_SEND    = 3'd1;
  localparam logic [STATE_W-1:0] ST_STUFF   = 3'd2;
  localparam logic [STATE_W-1:0] ST_EOP_SE0 = 3'd3;
  localparam logic [STATE_W-1:0] ST_EOP_J   = 3'd4;

  // NRZI: a 0 toggles J<->K, a 1 holds the level
  function automatic logic [1:0] nrzi(input logic [1:0] line, input logic bit_val);
    if (bit_val) return line;
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Free-running 0..23 bit timer; ticks at 7, 15 and 23 for 8 clocks per bit.
module usb_tx_bit_timer
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick_c
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  // Next count: wrap at the end of the span, clear on request
  always_comb begin
    cnt_d = cnt_q + 5'd1;
    if (clr || (cnt_q == 5'(TICK_PERIOD - 1))) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_tick_c = (cnt_q == TICK_A) || (cnt_q == TICK_B) || (cnt_q == TICK_C);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed TX bit engine: serialise LSB-first, bit stuff, NRZI, EOP.
// Optional feature macro: USB_TX_SYNC_GEN_EN (send SYNC from an internal constant).
module usb_tx_encoder
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_byte_req,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       dplus_out,
  output logic       dminus_out
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [7:0]         shreg_q, shreg_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [2:0]         ones_q, ones_d;
  logic [1:0]         eop_cnt_q, eop_cnt_d;
  logic               more_q, more_d;
  logic [1:0]         line_q, line_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               req_c;
  logic               bit_tick_c;
  logic               fetch_ok_c;
  logic               fetch_req_c;
  logic [7:0]         fetch_byte_c;
  logic               nbit_c;
  logic [2:0]         nxt_idx_c;
`ifdef USB_TX_SYNC_GEN_EN
  logic [7:0]         pend_q, pend_d;
  logic               sync_q, sync_d;
`endif

  usb_tx_bit_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_q == ST_IDLE),
    .bit_tick_c (bit_tick_c)
  );

  // Source of the byte that follows the current one
  always_comb begin
`ifdef USB_TX_SYNC_GEN_EN
    if (sync_q) begin
      fetch_ok_c   = 1'b1;
      fetch_req_c  = 1'b0;
      fetch_byte_c = pend_q;
    end else begin
      fetch_ok_c   = tx_data_valid;
      fetch_req_c  = tx_data_valid;
      fetch_byte_c = tx_data;
    end
`else
    fetch_ok_c   = tx_data_valid;
    fetch_req_c  = tx_data_valid;
    fetch_byte_c = tx_data;
`endif
  end

  // Next-state and datapath decode; everything advances on bit_tick
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    ones_d    = ones_q;
    eop_cnt_d = eop_cnt_q;
    more_d    = more_q;
    line_d    = line_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    req_c     = 1'b0;
    nbit_c    = 1'b0;
    nxt_idx_c = bit_idx_q + 3'd1;
`ifdef USB_TX_SYNC_GEN_EN
    pend_d    = pend_q;
    sync_d    = sync_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_start && tx_data_valid) begin
          req_c     = 1'b1;
          state_d   = ST_SEND;
          busy_d    = 1'b1;
          bit_idx_d = 3'd0;
`ifdef USB_TX_SYNC_GEN_EN
          shreg_d   = SYNC_BYTE;
          pend_d    = tx_data;
          sync_d    = 1'b1;
          nbit_c    = SYNC_BYTE[0];
`else
          shreg_d   = tx_data;
          nbit_c    = tx_data[0];
`endif
          line_d    = nrzi(LINE_J, nbit_c);
          ones_d    = 3'(nbit_c);
        end
      end
      ST_SEND: begin
        if (bit_tick_c) begin
          // Byte boundary: fetch even when a stuff bit comes first
          if (bit_idx_q == 3'd7) begin
            if (fetch_ok_c) begin
              req_c     = fetch_req_c;
              shreg_d   = fetch_byte_c;
              bit_idx_d = 3'd0;
`ifdef USB_TX_SYNC_GEN_EN
              sync_d    = 1'b0;
`endif
            end
          end else begin
            bit_idx_d = nxt_idx_c;
          end
          if (ones_q == 3'(STUFF_LEN)) begin
            state_d = ST_STUFF;
            line_d  = nrzi(line_q, 1'b0);
            ones_d  = 3'd0;
            more_d  = (bit_idx_q != 3'd7) || fetch_ok_c;
          end else if ((bit_idx_q != 3'd7) || fetch_ok_c) begin
            nbit_c = (bit_idx_q == 3'd7) ? fetch_byte_c[0] : shreg_q[nxt_idx_c];
            line_d = nrzi(line_q, nbit_c);
            ones_d = nbit_c ? (ones_q + 3'd1) : 3'd0;
          end else begin
            state_d   = ST_EOP_SE0;
            line_d    = LINE_SE0;
            eop_cnt_d = 2'd0;
          end
        end
      end
      ST_STUFF: begin
        if (bit_tick_c) begin
          if (more_q) begin
            nbit_c  = shreg_q[bit_idx_q];
            state_d = ST_SEND;
            line_d  = nrzi(line_q, nbit_c);
            ones_d  = nbit_c ? (ones_q + 3'd1) : 3'd0;
          end else begin
            state_d   = ST_EOP_SE0;
            line_d    = LINE_SE0;
            eop_cnt_d = 2'd0;
          end
        end
      end
      ST_EOP_SE0: begin
        if (bit_tick_c) begin
          if (eop_cnt_q == 2'(EOP_SE0_BITS - 1)) begin
            state_d = ST_EOP_J;
            line_d  = LINE_J;
          end else begin
            eop_cnt_d = eop_cnt_q + 2'd1;
          end
        end
      end
      ST_EOP_J: begin
        if (bit_tick_c) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          line_d  = LINE_J;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        line_d  = LINE_J;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      ones_q    <= '0;
      eop_cnt_q <= '0;
      more_q    <= 1'b0;
      line_q    <= LINE_J;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef USB_TX_SYNC_GEN_EN
      pend_q    <= '0;
      sync_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      ones_q    <= ones_d;
      eop_cnt_q <= eop_cnt_d;
      more_q    <= more_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef USB_TX_SYNC_GEN_EN
      pend_q    <= pend_d;
      sync_q    <= sync_d;
`endif
    end
  end

  // Byte request is a same-cycle handshake, held off while in reset
  assign tx_byte_req = req_c && !rst;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign dplus_out   = line_q[1];
  assign dminus_out  = line_q[0];

endmodule
